mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the data-side port of the 128-word instruction/data RAM (address, data, write-enable, size select, byte offset) between two requesters: r0 = core load/store unit, r1 = loader/debug master.
- Round-robin grant and valid/grant handshake; one access in flight.
- Converts byte addresses and access size into the RAM's word index, one-hot size select and offset.
- Aligns and extends load data, and flags misaligned or out-of-range accesses.

Parameters:
- MEM_WORDS, 128, number of 32-bit RAM words; word index >= MEM_WORDS is an error.
- AW, 32, requester byte-address width.

Ports:
- clk  in  1  clock; RAM writes on the same rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- rN_req  in  1  (N=0,1) request valid; fields held stable until granted.
- rN_we  in  1  1 = store, 0 = load.
- rN_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- rN_signed  in  1  load sign-extend (1) / zero-extend (0).
- rN_addr  in  AW  byte address.
- rN_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- rN_gnt  out  1  accept strobe; request taken at the clock edge where req && gnt.
- rN_resp_valid  out  1  one-cycle completion pulse.
- rN_rdata  out  32  load result, valid with resp_valid.
- rN_err  out  1  error flag, valid with resp_valid.
- mem_addr  out  32  word index (addr >> 2).
- mem_w_en  out  1  RAM write enable.
- mem_sel  out  4  0001 word, 0010 half, 0100 byte, 0000 idle.
- mem_offset  out  2  addr[1:0].
- mem_wdata  out  32  store data; top level drives it onto the RAM data bus when mem_w_en = 1.
- mem_rdata  in  32  combinational RAM read word.

Behaviour:
- States: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - gnt asserted to at most one requester.
  - If both request, grant the one not granted last (last_grant register, reset = 1, so r0 wins first).
  - A single requester is always granted.
  - On accept, register we, size, signed, addr, wdata and the requester id; go to ACCESS.
- Error check on the registered request:
  - size = 3 is an error.
  - half with addr[0] = 1 is an error.
  - word with addr[1:0] != 0 is an error.
  - addr[AW-1:2] >= MEM_WORDS is an error.
- ACCESS (one cycle):
  - Drive mem_addr, mem_sel and mem_offset from the registered request.
  - Store without error: mem_w_en = 1 for exactly this cycle, mem_wdata = wdata unshifted.
  - Load without error: capture mem_rdata at the end of the cycle.
  - Error: mem_sel = 0 and mem_w_en = 0; the RAM is untouched.
- RESP:
  - resp_valid = 1 to the owning requester only.
  - Load: rdata = extracted field. Byte = word[8*off +: 8]; half = word[16*off[1] +: 16]; sign- or zero-extended per signed.
  - Store or error: rdata = 0.
  - err = error flag.
  - Next state is IDLE.
- Latency: accept at edge k, resp_valid high in the cycle after edge k+2. Maximum throughput is one access per 3 cycles.
- gnt is low outside IDLE; a req held during ACCESS/RESP waits.
- rst_n = 0 at any edge, including mid-access:
  - state = IDLE, last_grant = 1.
  - All outputs 0 (gnt, resp_valid, rdata, err, mem_*).
  - No write issued in the following cycle.
  - An aborted access gets no response.
- Outputs rN_resp_valid, rN_rdata, rN_err and mem_* are registered; rN_gnt is combinational from state, req and last_grant.

Decomposition:
- Package mem_arb_pkg:
  - size encodings SZ_BYTE / SZ_HALF / SZ_WORD.
  - one-hot select constants SEL_WORD = 4'b0001, SEL_HALF = 4'b0010, SEL_BYTE = 4'b0100.
  - state encoding.
- Sub-module mem_load_align (combinational): word, size, offset, signed -> aligned 32-bit result.

Test Plan:
- r0 word store addr 0x10, data 0xDEADBEEF, then word load 0x10 -> mem_w_en one cycle with mem_addr = 4, mem_sel = 0001; load returns 0xDEADBEEF, err = 0, resp_valid exactly 2 cycles after the accept edge.
- r0 byte store 0x80 to addr 0x13, then r1 byte load 0x13 with signed = 1 and with signed = 0 -> mem_sel = 0100, offset = 3; rdata 0xFFFFFF80, then 0x00000080.
- r0 and r1 request every cycle -> grants alternate r0, r1, r0, ...; no double grant; each responds only to its owner.
- Half load addr 0x11, word store addr 0x02, size 3, word load addr 0x200 -> each err = 1, rdata = 0, mem_w_en never high, RAM contents unchanged.
- rst_n low in the ACCESS cycle of a store -> no mem_w_en pulse, no resp_valid, all outputs 0; next request after reset is granted to r0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the RAM data-port arbiter: access sizes, one-hot
// RAM size selects and the access FSM states.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_BAD  = 2'd3
    } size_e;

    localparam logic [3:0] SEL_IDLE = 4'b0000;
    localparam logic [3:0] SEL_WORD = 4'b0001;
    localparam logic [3:0] SEL_HALF = 4'b0010;
    localparam logic [3:0] SEL_BYTE = 4'b0100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    function automatic logic [3:0] size_to_sel(input logic [1:0] size);
        logic [3:0] sel;
        sel = SEL_IDLE;
        case (size)
            SZ_BYTE: sel = SEL_BYTE;
            SZ_HALF: sel = SEL_HALF;
            SZ_WORD: sel = SEL_WORD;
            default: sel = SEL_IDLE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// One requester's view of the shared RAM data port: request fields,
// accept strobe and the registered completion.
interface mem_req_if #(
    parameter int AW = 32
);
    logic          req;
    logic          we;
    logic [1:0]    size;
    logic          is_signed;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          gnt;
    logic          resp_valid;
    logic [31:0]   rdata;
    logic          err;

    modport master (
        output req, we, size, is_signed, addr, wdata,
        input  gnt, resp_valid, rdata, err
    );

    modport slave (
        input  req, we, size, is_signed, addr, wdata,
        output gnt, resp_valid, rdata, err
    );
endinterface

// File: rtl/mem_port_arbiter_load_align.sv
// Extracts the addressed byte/half/word from a RAM word and sign- or
// zero-extends it to 32 bits.
module mem_load_align
    import mem_arb_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_signed,
    output logic [31:0] result
);
    logic [7:0]  byte_field;
    logic [15:0] half_field;

    assign byte_field = word[{offset, 3'b000} +: 8];
    assign half_field = word[{offset[1], 4'b0000} +: 16];

    always_comb begin
        result = '0;
        case (size)
            SZ_BYTE: result = {{24{is_signed & byte_field[7]}}, byte_field};
            SZ_HALF: result = {{16{is_signed & half_field[15]}}, half_field};
            SZ_WORD: result = word;
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the RAM data port between the load/store unit
// (r0) and the loader/debug master (r1); one access in flight at a time.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_WORDS = 128,
    parameter int AW        = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_req_if.slave    r0,
    mem_req_if.slave    r1,
    output logic [31:0] mem_addr,
    output logic        mem_w_en,
    output logic [3:0]  mem_sel,
    output logic [1:0]  mem_offset,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    state_e        state_reg, state_next;
    logic          gnt0, gnt1, accept;
    logic          last_grant_reg;

    logic          in_we, in_signed, in_err;
    logic [1:0]    in_size;
    logic [AW-1:0] in_addr;
    logic [31:0]   in_wdata;

    logic          owner_reg, we_reg, signed_reg, err_reg;
    logic [1:0]    size_reg, offset_reg;
    logic [31:0]   ld_word_reg, ld_aligned;

    logic [31:0]   mem_addr_reg, mem_wdata_reg;
    logic          mem_w_en_reg;
    logic [3:0]    mem_sel_reg;
    logic [1:0]    mem_offset_reg;

    logic          resp0_reg, resp1_reg, rerr0_reg, rerr1_reg;
    logic [31:0]   rdata0_reg, rdata1_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Grants are combinational so a waiting requester is taken on the first
    // IDLE edge; held low during reset so nothing can look accepted.
    always_comb begin
        state_next = state_reg;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (rst_n) begin
                    if (r0.req && r1.req) begin
                        gnt0 = last_grant_reg;
                        gnt1 = ~last_grant_reg;
                    end else begin
                        gnt0 = r0.req;
                        gnt1 = r1.req;
                    end
                end
                if (gnt0 || gnt1) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    assign accept    = gnt0 | gnt1;
    assign in_we     = gnt1 ? r1.we        : r0.we;
    assign in_size   = gnt1 ? r1.size      : r0.size;
    assign in_signed = gnt1 ? r1.is_signed : r0.is_signed;
    assign in_addr   = gnt1 ? r1.addr      : r0.addr;
    assign in_wdata  = gnt1 ? r1.wdata     : r0.wdata;

    always_comb begin
        in_err = 1'b0;
        case (in_size)
            SZ_HALF: in_err = in_addr[0];
            SZ_WORD: in_err = (in_addr[1:0] != 2'b00);
            SZ_BAD:  in_err = 1'b1;
            default: in_err = 1'b0;
        endcase
        if (in_addr[AW-1:2] >= (AW-2)'(MEM_WORDS)) begin
            in_err = 1'b1;
        end
    end

    mem_load_align u_align (
        .word      (ld_word_reg),
        .size      (size_reg),
        .offset    (offset_reg),
        .is_signed (signed_reg),
        .result    (ld_aligned)
    );

    // The RAM-facing bus is loaded at the accept edge so it is valid for
    // exactly the ACCESS cycle, then returns to idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_reg <= 1'b1;
            owner_reg      <= 1'b0;
            we_reg         <= 1'b0;
            signed_reg     <= 1'b0;
            err_reg        <= 1'b0;
            size_reg       <= 2'd0;
            offset_reg     <= 2'd0;
            ld_word_reg    <= '0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_w_en_reg   <= 1'b0;
            mem_sel_reg    <= SEL_IDLE;
            mem_offset_reg <= 2'd0;
            resp0_reg      <= 1'b0;
            resp1_reg      <= 1'b0;
            rerr0_reg      <= 1'b0;
            rerr1_reg      <= 1'b0;
            rdata0_reg     <= '0;
            rdata1_reg     <= '0;
        end else begin
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_w_en_reg   <= 1'b0;
            mem_sel_reg    <= SEL_IDLE;
            mem_offset_reg <= 2'd0;
            resp0_reg      <= 1'b0;
            resp1_reg      <= 1'b0;
            rerr0_reg      <= 1'b0;
            rerr1_reg      <= 1'b0;
            rdata0_reg     <= '0;
            rdata1_reg     <= '0;

            if (accept) begin
                last_grant_reg <= gnt1;
                owner_reg      <= gnt1;
                we_reg         <= in_we;
                signed_reg     <= in_signed;
                err_reg        <= in_err;
                size_reg       <= in_size;
                offset_reg     <= in_addr[1:0];
                mem_addr_reg   <= 32'(in_addr[AW-1:2]);
                mem_offset_reg <= in_addr[1:0];
                mem_sel_reg    <= in_err ? SEL_IDLE : size_to_sel(in_size);
                mem_w_en_reg   <= in_we & ~in_err;
                mem_wdata_reg  <= (in_we && !in_err) ? in_wdata : '0;
            end

            if (state_reg == ST_ACCESS) begin
                ld_word_reg <= mem_rdata;
            end

            if (state_reg == ST_RESP) begin
                if (owner_reg) begin
                    resp1_reg  <= 1'b1;
                    rerr1_reg  <= err_reg;
                    rdata1_reg <= (!we_reg && !err_reg) ? ld_aligned : '0;
                end else begin
                    resp0_reg  <= 1'b1;
                    rerr0_reg  <= err_reg;
                    rdata0_reg <= (!we_reg && !err_reg) ? ld_aligned : '0;
                end
            end
        end
    end

    assign r0.gnt        = gnt0;
    assign r1.gnt        = gnt1;
    assign r0.resp_valid = resp0_reg;
    assign r1.resp_valid = resp1_reg;
    assign r0.rdata      = rdata0_reg;
    assign r1.rdata      = rdata1_reg;
    assign r0.err        = rerr0_reg;
    assign r1.err        = rerr1_reg;

    // Write enable is masked by reset so a reset landing in the ACCESS cycle
    // kills the pending RAM write at the next edge.
    assign mem_addr   = mem_addr_reg;
    assign mem_w_en   = mem_w_en_reg & rst_n;
    assign mem_sel    = mem_sel_reg;
    assign mem_offset = mem_offset_reg;
    assign mem_wdata  = mem_wdata_reg;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, randomized accesses
// against a byte-array memory model, reset abort and contention sequences.
module tb_mem_port_arbiter;
    localparam int MEM_WORDS = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_w_en;
    logic [3:0]  mem_sel;
    logic [1:0]  mem_offset;

    mem_req_if #(.AW(32)) i0 ();
    mem_req_if #(.AW(32)) i1 ();

    mem_port_arbiter #(.MEM_WORDS(MEM_WORDS), .AW(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .r0         (i0),
        .r1         (i1),
        .mem_addr   (mem_addr),
        .mem_w_en   (mem_w_en),
        .mem_sel    (mem_sel),
        .mem_offset (mem_offset),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM attached to the data port, little-endian byte lanes.
    logic [31:0] ram [MEM_WORDS] = '{default: 32'd0};
    assign mem_rdata = ram[mem_addr[6:0]];
    always @(posedge clk) begin
        if (mem_w_en && mem_addr < 32'(MEM_WORDS)) begin
            case (mem_sel)
                4'b0001: ram[mem_addr[6:0]] <= mem_wdata;
                4'b0010: ram[mem_addr[6:0]][{mem_offset[1], 4'b0000} +: 16] <= mem_wdata[15:0];
                4'b0100: ram[mem_addr[6:0]][{mem_offset, 3'b000} +: 8] <= mem_wdata[7:0];
                default: ;
            endcase
        end
    end

    int vectors = 0;
    int miscompares = 0;
    int exp_writes = 0;
    int wen_cycles = 0;
    logic [7:0] ref_mem [MEM_WORDS*4] = '{default: 8'd0};

    function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic void chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        chk1("no_double_gnt", i0.gnt & i1.gnt, 1'b0);
        if (mem_w_en) wen_cycles++;
    end

    // Reference: byte-addressed memory, access rules applied directly.
    function automatic void model(input logic we, input logic [1:0] sz, input logic sg,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic er);
        int n;
        logic [31:0] v;
        er = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)
             || (a >= 32'(MEM_WORDS * 4));
        rd = '0;
        if (er) return;
        n = 1 << sz;
        if (we) begin
            for (int i = 0; i < n; i++) ref_mem[a[8:0] + 9'(i)] = wd[8*i +: 8];
            exp_writes++;
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a[8:0] + 9'(i)];
            if (sg && v[8*n-1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
            rd = v;
        end
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {ref_mem[a[8:0] + 9'd3], ref_mem[a[8:0] + 9'd2],
                ref_mem[a[8:0] + 9'd1], ref_mem[a[8:0]]};
    endfunction

    function automatic logic gnt_of(input int id);
        return (id == 1) ? i1.gnt : i0.gnt;
    endfunction
    function automatic logic resp_of(input int id);
        return (id == 1) ? i1.resp_valid : i0.resp_valid;
    endfunction

    task automatic drive(input int id, input logic req, input logic we, input logic [1:0] sz,
                         input logic sg, input logic [31:0] addr, input logic [31:0] wd);
        if (id == 1) begin
            i1.req = req; i1.we = we; i1.size = sz; i1.is_signed = sg; i1.addr = addr; i1.wdata = wd;
        end else begin
            i0.req = req; i0.we = we; i0.size = sz; i0.is_signed = sg; i0.addr = addr; i0.wdata = wd;
        end
    endtask

    // Called just after a rising edge with the DUT idle; returns just after
    // the edge that ends the response pulse.
    task automatic do_access(input int id, input logic we, input logic [1:0] sz, input logic sg,
                             input logic [31:0] addr, input logic [31:0] wd, input logic exp_er,
                             output logic [31:0] rd, output logic er);
        logic got;
        logic exp_wen;
        logic [3:0] exp_sel;
        rd = '0;
        er = 1'b0;
        got = 1'b0;
        exp_wen = we & ~exp_er;
        exp_sel = exp_er ? 4'b0000 : (sz == 2'd0) ? 4'b0100 : (sz == 2'd1) ? 4'b0010 : 4'b0001;
        drive(id, 1'b1, we, sz, sg, addr, wd);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (gnt_of(id)) begin
                got = 1'b1;
                break;
            end
        end
        chk1("gnt_timeout", got, 1'b1);
        if (!got) begin
            drive(id, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        drive(id, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        chk32("acc_mem_addr", mem_addr, {2'b00, addr[31:2]});
        chk32("acc_mem_sel", 32'(mem_sel), 32'(exp_sel));
        chk32("acc_mem_offset", 32'(mem_offset), 32'(addr[1:0]));
        chk1("acc_mem_w_en", mem_w_en, exp_wen);
        chk32("acc_mem_wdata", mem_wdata, exp_wen ? wd : 32'd0);
        chk1("acc_no_resp", i0.resp_valid | i1.resp_valid, 1'b0);
        @(posedge clk); #1;
        chk1("resp_cyc_w_en", mem_w_en, 1'b0);
        chk32("resp_cyc_sel", 32'(mem_sel), 32'd0);
        chk1("resp_cyc_no_resp", i0.resp_valid | i1.resp_valid, 1'b0);
        @(posedge clk); #1;
        chk1("resp_valid_owner", resp_of(id), 1'b1);
        chk1("resp_valid_other", resp_of(1 - id), 1'b0);
        rd = (id == 1) ? i1.rdata : i0.rdata;
        er = (id == 1) ? i1.err : i0.err;
        @(posedge clk); #1;
        chk1("resp_one_cycle", resp_of(id), 1'b0);
        $display("txn r%0d we=%0d size=%0d signed=%0d addr=%h wdata=%h -> rdata=%h err=%0d",
                 id, we, sz, sg, addr, wd, rd, er);
    endtask

    typedef struct {
        int          id;
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_er;
    } vec_t;

    vec_t tbl [20];

    initial begin
        logic [31:0] rd, mrd, w0, w1;
        logic        er, mer, got, drop;
        int          g0, g1, r0n, r1n, ng;
        int          order [16];

        drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b1, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_gnt0", i0.gnt, 1'b0);
        chk1("rst_gnt1", i1.gnt, 1'b0);
        chk1("rst_resp0", i0.resp_valid, 1'b0);
        chk1("rst_resp1", i1.resp_valid, 1'b0);
        chk32("rst_rdata0", i0.rdata, 32'd0);
        chk32("rst_mem_addr", mem_addr, 32'd0);
        chk32("rst_mem_sel", 32'(mem_sel), 32'd0);
        chk1("rst_mem_w_en", mem_w_en, 1'b0);
        drive(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        tbl[0]  = '{0, 1'b1, 2'd2, 1'b0, 32'h10,       32'hDEADBEEF, 32'h00000000, 1'b0};
        tbl[1]  = '{0, 1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{0, 1'b1, 2'd0, 1'b0, 32'h13,       32'h00000080, 32'h00000000, 1'b0};
        tbl[3]  = '{1, 1'b0, 2'd0, 1'b1, 32'h13,       32'h0,        32'hFFFFFF80, 1'b0};
        tbl[4]  = '{1, 1'b0, 2'd0, 1'b0, 32'h13,       32'h0,        32'h00000080, 1'b0};
        tbl[5]  = '{1, 1'b0, 2'd1, 1'b1, 32'h12,       32'h0,        32'hFFFF80AD, 1'b0};
        tbl[6]  = '{0, 1'b0, 2'd1, 1'b0, 32'h10,       32'h0,        32'h0000BEEF, 1'b0};
        tbl[7]  = '{0, 1'b0, 2'd0, 1'b1, 32'h11,       32'h0,        32'hFFFFFFBE, 1'b0};
        tbl[8]  = '{0, 1'b0, 2'd1, 1'b0, 32'h11,       32'h0,        32'h00000000, 1'b1};
        tbl[9]  = '{0, 1'b1, 2'd2, 1'b0, 32'h02,       32'h11223344, 32'h00000000, 1'b1};
        tbl[10] = '{1, 1'b1, 2'd3, 1'b0, 32'h10,       32'hFFFFFFFF, 32'h00000000, 1'b1};
        tbl[11] = '{1, 1'b0, 2'd2, 1'b0, 32'h200,      32'h0,        32'h00000000, 1'b1};
        tbl[12] = '{0, 1'b1, 2'd2, 1'b0, 32'h200,      32'h55AA55AA, 32'h00000000, 1'b1};
        tbl[13] = '{0, 1'b0, 2'd2, 1'b0, 32'h00,       32'h0,        32'h00000000, 1'b0};
        tbl[14] = '{1, 1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        32'h80ADBEEF, 1'b0};
        tbl[15] = '{1, 1'b1, 2'd1, 1'b0, 32'h1FE,      32'hFFFFCAFE, 32'h00000000, 1'b0};
        tbl[16] = '{0, 1'b0, 2'd2, 1'b0, 32'h1FC,      32'h0,        32'hCAFE0000, 1'b0};
        tbl[17] = '{0, 1'b0, 2'd0, 1'b1, 32'h1FF,      32'h0,        32'hFFFFFFCA, 1'b0};
        tbl[18] = '{1, 1'b0, 2'd3, 1'b0, 32'h00,       32'h0,        32'h00000000, 1'b1};
        tbl[19] = '{0, 1'b0, 2'd2, 1'b0, 32'h7FFFFFFC, 32'h0,        32'h00000000, 1'b1};

        for (int v = 0; v < 20; v++) begin
            model(tbl[v].we, tbl[v].sz, tbl[v].sg, tbl[v].addr, tbl[v].wd, mrd, mer);
            do_access(tbl[v].id, tbl[v].we, tbl[v].sz, tbl[v].sg, tbl[v].addr, tbl[v].wd,
                      tbl[v].exp_er, rd, er);
            chk32("tbl_rdata", rd, tbl[v].exp_rd);
            chk1("tbl_err", er, tbl[v].exp_er);
        end

        for (int n = 0; n < 150; n++) begin
            int          id, pick;
            logic        we, sg;
            logic [1:0]  sz;
            logic [31:0] a, wd;
            id   = int'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            sg   = 1'($urandom_range(0, 1));
            sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            pick = int'($urandom_range(0, 9));
            wd   = $urandom;
            if (pick == 0) a = $urandom;
            else a = 32'($urandom_range(0, MEM_WORDS * 4 - 1));
            if (pick >= 1 && pick <= 7 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            model(we, sz, sg, a, wd, mrd, mer);
            do_access(id, we, sz, sg, a, wd, mer, rd, er);
            chk32("rand_rdata", rd, mrd);
            chk1("rand_err", er, mer);
        end

        // Reset lands in the ACCESS cycle of a store.
        w0 = ref_word(32'h40);
        drive(0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h40, ~w0);
        got = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (i0.gnt) begin
                got = 1'b1;
                break;
            end
        end
        chk1("abort_gnt_timeout", got, 1'b1);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        chk1("abort_pre_w_en", mem_w_en, got);
        rst_n = 1'b0;
        #1;
        chk1("abort_w_en_masked", mem_w_en, 1'b0);
        @(posedge clk); #1;
        chk1("abort_gnt0", i0.gnt, 1'b0);
        chk1("abort_resp0", i0.resp_valid, 1'b0);
        chk1("abort_resp1", i1.resp_valid, 1'b0);
        chk32("abort_rdata0", i0.rdata, 32'd0);
        chk1("abort_err0", i0.err, 1'b0);
        chk32("abort_mem_addr", mem_addr, 32'd0);
        chk32("abort_mem_sel", 32'(mem_sel), 32'd0);
        chk32("abort_mem_offset", 32'(mem_offset), 32'd0);
        chk32("abort_mem_wdata", mem_wdata, 32'd0);
        chk1("abort_mem_w_en", mem_w_en, 1'b0);
        @(posedge clk); #1;
        chk1("abort_no_late_resp", i0.resp_valid | i1.resp_valid, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk1("abort_no_resp_after", i0.resp_valid | i1.resp_valid, 1'b0);
        chk32("abort_ram_untouched", ram[16], w0);

        // Both requesters hold a load: grants alternate starting with r0.
        model(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, w0, mer);
        model(1'b0, 2'd2, 1'b0, 32'h1FC, 32'd0, w1, mer);
        drive(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
        drive(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h1FC, 32'd0);
        ng = 0; r0n = 0; r1n = 0; drop = 1'b0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            g0 = int'(i0.gnt);
            g1 = int'(i1.gnt);
            if ((g0 + g1) != 0 && ng < 16) begin
                order[ng] = g1;
                ng++;
                if (ng == 8) drop = 1'b1;
            end
            if (i0.resp_valid) begin
                r0n++;
                chk32("alt_rdata0", i0.rdata, w0);
            end
            if (i1.resp_valid) begin
                r1n++;
                chk32("alt_rdata1", i1.rdata, w1);
            end
            @(posedge clk); #1;
            if (drop) begin
                drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
                drive(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
                drop = 1'b0;
            end
        end
        chk32("alt_grant_count", 32'(ng), 32'd8);
        for (int i = 0; i < 8; i++) chk32("alt_order", 32'(order[i]), 32'(i % 2));
        chk32("alt_resp0_count", 32'(r0n), 32'd4);
        chk32("alt_resp1_count", 32'(r1n), 32'd4);

        chk32("write_pulses", 32'(wen_cycles), 32'(exp_writes));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
